// File: rtl/param_data_ram.sv
// param_data_ram: byte-addressed, word-organised data RAM for the MEM stage.
// Byte/halfword/word accesses, sign/zero extended loads, strict alignment
// checking, registered read result with a one-cycle rvalid pulse, and a
// sequential zeroing sweep after clr before the block accepts requests.
// Optional build macro: RAM_BIG_ENDIAN_EN reverses the byte lane mapping.
//
// state    | meaning
// ST_CLEAR | zeroing sweep, one word per cycle, ready=0
// ST_IDLE  | accepting load/store requests, ready=1
module param_data_ram #(
  parameter int ADDR_W           = 12,
  parameter int PROBE_EN_DEFAULT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Mode,
  input  logic              sign_ext,
  input  logic [31:0]       data_in,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       data_out,
  output logic              misalign,
  input  logic [ADDR_W-3:0] probe_addr,
  output logic [31:0]       mem_probe
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             rvalid_q, rvalid_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      data_out_q, data_out_d;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [1:0]       lane;
  logic             accept;
  logic             aligned;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_val;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  assign idx    = Addr[ADDR_W-1:2];
  assign off    = Addr[1:0];
  assign ready  = (state_q == ST_IDLE);
  assign accept = req & ready & ~clr;

  // Physical byte lane selected by the address offset; halfwords use lane[1].
`ifdef RAM_BIG_ENDIAN_EN
  assign lane = off ^ 2'b11;
`else
  assign lane = off;
`endif

  assign rd_word = mem[idx];
  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  assign mem_probe = (PROBE_EN_DEFAULT != 0) ? mem[probe_addr] : 32'h0;

  // Alignment rule per access size; Mode=11 is never a legal access.
  always_comb begin
    aligned = 1'b0;
    case (Mode)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~Addr[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  // Load result extraction and extension.
  always_comb begin
    ld_val = rd_word;
    case (Mode)
      2'b00:   ld_val = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: ld_val = rd_word;
    endcase
  end

  // Next-state, array write port and result computation.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    mem_idx    = idx;
    mem_be     = 4'b0000;
    mem_wdata  = 32'h0;
    case (state_q)
      ST_CLEAR: begin
        if (!clr) begin
          mem_we    = 1'b1;
          mem_idx   = ptr_q;
          mem_be    = 4'b1111;
          mem_wdata = 32'h0;
          ptr_d     = ptr_q + IDX_W'(1);
          if (ptr_q == {IDX_W{1'b1}}) state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          rvalid_d = 1'b1;
          if (!aligned) begin
            misalign_d = 1'b1;
            data_out_d = 32'h0;
          end else if (we) begin
            mem_we = 1'b1;
            case (Mode)
              2'b00: begin
                mem_be    = 4'b0001 << lane;
                mem_wdata = {4{data_in[7:0]}};
              end
              2'b01: begin
                mem_be    = lane[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{data_in[15:0]}};
              end
              default: begin
                mem_be    = 4'b1111;
                mem_wdata = data_in;
              end
            endcase
          end else begin
            data_out_d = ld_val;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control and result registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_CLEAR;
      ptr_q      <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      data_out_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      data_out_q <= data_out_d;
    end
  end

  // Byte-enabled array write; clr suppresses writes via mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign rvalid   = rvalid_q;
  assign misalign = misalign_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_param_data_ram.sv
// Scoreboard bench for param_data_ram: the driver pushes expected results,
// a monitor pops and compares on every rvalid pulse.
module tb_param_data_ram;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [11:0] Addr = '0;
  logic [1:0]  Mode = 2'b10;
  logic        sign_ext = 1'b0;
  logic [31:0] data_in = '0;
  logic        ready;
  logic        rvalid;
  logic [31:0] data_out;
  logic        misalign;
  logic [9:0]  probe_addr = '0;
  logic [31:0] mem_probe;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        mis;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

`ifdef RAM_BIG_ENDIAN_EN
  localparam logic [31:0] B013 = 32'h0000_0078;
  localparam logic [31:0] B010 = 32'h0000_0012;
  localparam logic [31:0] H012 = 32'h0000_5678;
  localparam logic [31:0] W020 = 32'h0080_BEEF;
`else
  localparam logic [31:0] B013 = 32'h0000_0012;
  localparam logic [31:0] B010 = 32'h0000_0078;
  localparam logic [31:0] H012 = 32'h0000_1234;
  localparam logic [31:0] W020 = 32'hBEEF_8000;
`endif

  param_data_ram #(.ADDR_W(12), .PROBE_EN_DEFAULT(1)) dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .Addr(Addr), .Mode(Mode),
    .sign_ext(sign_ext), .data_in(data_in), .ready(ready), .rvalid(rvalid),
    .data_out(data_out), .misalign(misalign), .probe_addr(probe_addr),
    .mem_probe(mem_probe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge; it is accepted at the following posedge.
  task automatic acc(input logic w, input logic [11:0] a, input logic [1:0] m,
                     input logic sx, input logic [31:0] din,
                     input logic exp_mis, input logic [31:0] exp_d);
    int t = 0;
    while (ready !== 1'b1 && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: ready=%b expected 1", ready);
    end
    req = 1'b1; we = w; Addr = a; Mode = m; sign_ext = sx; data_in = din;
    sb.push_back('{mis: exp_mis, data: exp_d});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every rvalid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: data_out=0x%08h misalign=%b", data_out, misalign);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", data_out, e.data);
        chk("rd_misalign", {31'h0, misalign}, {31'h0, e.mis});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'h0, ready}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_data_out", data_out, 32'h0);

    clr = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    chk("sweep_cycles", cnt, 32'd1024);

    acc(0, 12'h3FC, 2'b10, 0, 32'h0, 0, 32'h0000_0000);
    acc(1, 12'h010, 2'b10, 0, 32'h1234_5678, 0, 32'h0000_0000);
    acc(0, 12'h013, 2'b00, 0, 32'h0, 0, B013);
    acc(0, 12'h010, 2'b00, 0, 32'h0, 0, B010);
    acc(0, 12'h012, 2'b01, 0, 32'h0, 0, H012);
    acc(0, 12'h010, 2'b10, 0, 32'h0, 0, 32'h1234_5678);
    acc(1, 12'h021, 2'b00, 0, 32'h0000_0080, 0, 32'h1234_5678);
    acc(0, 12'h021, 2'b00, 1, 32'h0, 0, 32'hFFFF_FF80);
    acc(0, 12'h021, 2'b00, 0, 32'h0, 0, 32'h0000_0080);
    acc(1, 12'h022, 2'b01, 0, 32'h0000_BEEF, 0, 32'h0000_0080);
    acc(0, 12'h020, 2'b10, 0, 32'h0, 0, W020);
    acc(0, 12'h022, 2'b01, 1, 32'h0, 0, 32'hFFFF_BEEF);
    acc(1, 12'h031, 2'b10, 0, 32'hDEAD_BEEF, 1, 32'h0);
    acc(0, 12'h010, 2'b10, 0, 32'h0, 0, 32'h1234_5678);
    acc(0, 12'h033, 2'b01, 0, 32'h0, 1, 32'h0);
    acc(0, 12'h010, 2'b10, 0, 32'h0, 0, 32'h1234_5678);
    acc(0, 12'h000, 2'b11, 0, 32'h0, 1, 32'h0);
    acc(1, 12'h023, 2'b01, 0, 32'h0000_FFFF, 1, 32'h0);
    idle(2);

    probe_addr = 10'h00C; #1;
    chk("probe_misaligned_store", mem_probe, 32'h0);
    probe_addr = 10'h008; #1;
    chk("probe_word8", mem_probe, W020);
    probe_addr = 10'h004; #1;
    chk("probe_word4", mem_probe, 32'h1234_5678);
    @(negedge clk);

    acc(1, 12'h040, 2'b10, 0, 32'hA5A5_A5A5, 0, 32'h0000_0000);
    acc(0, 12'h040, 2'b10, 0, 32'h0, 0, 32'hA5A5_A5A5);
    idle(2);

    // Request issued in the same cycle as clr: must be dropped.
    req = 1'b1; we = 1'b0; Addr = 12'h040; Mode = 2'b10; clr = 1'b1;
    @(negedge clk);
    req = 1'b0; clr = 1'b0;
    chk("clr_rvalid", {31'h0, rvalid}, 32'h0);
    chk("clr_ready", {31'h0, ready}, 32'h0);
    chk("clr_data_out", data_out, 32'h0);

    probe_addr = 10'h010;
    repeat (3) @(negedge clk);
    chk("probe_before_sweep", mem_probe, 32'hA5A5_A5A5);
    repeat (20) @(negedge clk);
    chk("probe_after_sweep", mem_probe, 32'h0);

    cnt = 0;
    while (ready !== 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    chk("ready_after_reclear", {31'h0, ready}, 32'h1);
    acc(0, 12'h040, 2'b10, 0, 32'h0, 0, 32'h0);
    idle(4);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
